mc_ctrl_fsm: RTL

Parametrised multicycle MIPS control unit.
- Decodes the IR opcode into the per-cycle datapath controls: PC, IR, register file, ALU muxes and memory enables.
- Adds asynchronous reset, a memory-ready wait handshake, illegal-opcode detection and a retired-instruction counter.
- Sits between the instruction register and the multicycle datapath; one instance per core.

---
 rtl/mc_ctrl_pkg.sv | 55 +++++
 rtl/mc_ctrl_decode.sv | 68 ++++++
 rtl/mc_ctrl_fsm.sv | 116 +++++++++++
 3 files changed

// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - opcode and state codes, control-word layout for the multicycle MIPS control unit.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  localparam int CTRL_W = 16;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // States whose exit into FETCH completes an instruction.
  function automatic logic is_retire_state(input state_e s);
    case (s)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JUMP: is_retire_state = 1'b1;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIWB: is_retire_state = 1'b1;
`endif
      default: is_retire_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// rtl/mc_ctrl_decode.sv - combinational state-to-control-word decode (MC_CTRL_ADDI_EN adds the ADDI states).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0]        state,
  input  logic              mem_ready,
  output logic [CTRL_W-1:0] ctrl
);

  ctrl_t c;

  always_comb begin
    c = '0;
    case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDIWB: c.reg_write = 1'b1;
`endif
      default: c = '0;
    endcase
    ctrl = c;
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS control FSM with wait handshake, illegal-op pulse and retire counter (MC_CTRL_ADDI_EN enables ADDI).
module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int STATE_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [OP_W-1:0]    op,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   retired
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_d;
  logic [CTRL_W-1:0] ctrl_raw;
  ctrl_t            ctrl;

  logic is_lw, is_sw, is_rtype, is_beq, is_j, is_addi;

  assign is_lw    = (op == OP_W'(OP_LW));
  assign is_sw    = (op == OP_W'(OP_SW));
  assign is_rtype = (op == OP_W'(OP_RTYPE));
  assign is_beq   = (op == OP_W'(OP_BEQ));
  assign is_j     = (op == OP_W'(OP_J));
  assign is_addi  = (op == OP_W'(OP_ADDI));

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_lw || is_sw)  state_d = S_MEMADR;
        else if (is_rtype)   state_d = S_EXEC;
        else if (is_beq)     state_d = S_BRANCH;
        else if (is_j)       state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
        else if (is_addi)    state_d = S_ADDIEX;
`endif
        else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_MEMADR: begin
        if (is_lw)      state_d = S_MEMRD;
        else if (is_sw) state_d = S_MEMWR;
        else            state_d = S_FETCH;
      end
      S_MEMRD: if (mem_ready) state_d = S_MEMWB;
      S_MEMWR: if (mem_ready) state_d = S_FETCH;
      S_EXEC:  state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
      S_ADDIEX: state_d = S_ADDIWB;
`endif
      default: state_d = S_FETCH;
    endcase
    if (state_d == S_FETCH && is_retire_state(state_q))
      retired_d = retired_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  mc_ctrl_decode u_decode (
    .state     (state_q),
    .mem_ready (mem_ready),
    .ctrl      (ctrl_raw)
  );

  assign ctrl          = ctrl_t'(ctrl_raw);
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign iord          = ctrl.iord;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign ir_write      = ctrl.ir_write;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign reg_dst       = ctrl.reg_dst;
  assign reg_write     = ctrl.reg_write;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign pc_source     = ctrl.pc_source;
  assign illegal_op    = illegal_d;
  assign state         = STATE_W'(state_q);
  assign retired       = retired_q;

endmodule
